alu_ctrl_seq: RTL
=================

Name: alu_ctrl_seq

Overview:
- Parametrised, registered successor to the combinational ALU control decoder.
- Decodes aluop/funct7/funct3 into an extended ALU control word, covering RV32I R/I-type ops, branches, and RV32M multiply/divide.
- Adds a valid/ready pipeline stage and a latency-counting FSM, so multi-cycle MUL/DIV ops hold the issue stage until the execute unit's result is due.
- Sits between decode and execute in the core pipeline.

Parameters:
- CTRL_W, 5: width of alu_ctrl. Must be ≥5; upper bits beyond 5 are zero.
- MUL_LAT, 3: cycles from MUL-class acceptance to out_valid. Must be ≥1.
- DIV_LAT, 33: cycles from DIV/REM-class acceptance to out_valid. Must be ≥1.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  kill any pending/held op (pipeline redirect).
- in_valid  in  1  decode presents an op.
- in_ready  out  1  block accepts the op this cycle.
- aluop  in  2  00 load/store/jalr, 01 branch, 10 R-type, 11 I-type ALU.
- funct7  in  7  instruction funct7.
- funct3  in  3  instruction funct3.
- out_valid  out  1  alu_ctrl valid to execute.
- out_ready  in  1  execute consumes alu_ctrl.
- alu_ctrl  out  CTRL_W  registered control word.
- is_muldiv  out  1  registered; held op is RV32M.
- busy  out  1  FSM in WAIT.

Behaviour:
- Decode, combinational and internal. Result is 5 bits, zero-extended to CTRL_W:
  - aluop 10, funct7 = 0000001: {1,0,funct3}, flagged muldiv.
  - aluop 10, otherwise: {0,funct7[5],funct3}.
  - aluop 11: {0,(funct3==101)&funct7[5],funct3}. Only SRAI uses funct7[5]; ADDI never becomes SUB.
  - aluop 00: 00000.
  - aluop 01, funct3 000/001: 01000.
  - aluop 01, funct3 100/101: 00010.
  - aluop 01, funct3 110/111: 00011.
  - aluop 01, funct3 010/011: 01010. No latch, default applies.
  - Any other input: 01010.
- Accept = in_valid & in_ready & ~flush.
- in_ready = (state==IDLE) | (state==VALID & out_ready). Back-to-back single-cycle ops sustain one per cycle. in_ready is 0 in WAIT.
- FSM states IDLE, WAIT, VALID:
  - IDLE, accept of a non-muldiv op → VALID. alu_ctrl/is_muldiv are loaded; out_valid is 1 the next cycle (1-cycle latency).
  - IDLE/VALID, accept of a muldiv op:
    - LAT = MUL_LAT when funct3[2]==0, else DIV_LAT.
    - LAT==1 → VALID.
    - Otherwise → WAIT with cnt = LAT-2.
    - out_valid rises exactly LAT cycles after the accept edge.
  - WAIT: cnt==0 → VALID, else cnt decrements. Input is ignored.
  - VALID:
    - out_ready with accept → load the new op, following the IDLE rules.
    - out_ready without accept → IDLE.
    - No out_ready → hold. alu_ctrl must remain stable.
- out_valid = (state==VALID). busy = (state==WAIT).
- flush, any state → IDLE next cycle. flush beats a simultaneous accept and out_ready, and no op is loaded.
- Counter width is $clog2(max(MUL_LAT,DIV_LAT)+1).
- rst:
  - Applies in any state, including mid-WAIT, and overrides flush and accept.
  - Next edge: state IDLE, cnt 0, alu_ctrl 0, is_muldiv 0, out_valid 0, busy 0.
  - in_ready is 1 in the cycle after reset.
- Elaboration error if MUL_LAT<1, DIV_LAT<1, or CTRL_W<5.

Decomposition:
- Package alu_ctrl_pkg holds:
  - aluop_e enum (ALUOP_MEM, ALUOP_BR, ALUOP_R, ALUOP_I).
  - 5-bit control codes: CTRL_ADD=00000, CTRL_SUB_CMP=01000, CTRL_LT=00010, CTRL_LTU=00011, CTRL_DEFAULT=01010.
  - FUNCT7_MULDIV=0000001.
  - State enum.
- One sub-module, alu_ctrl_decode: pure combinational decode producing the 5-bit code and the muldiv flag. The top holds the FSM, counter and output registers.

Test Plan:
- Back-to-back ops with out_ready=1: issue aluop 10 funct7 0100000 funct3 000, then aluop 11 funct7 0100000 funct3 000 → alu_ctrl 01000 then 00000, each one cycle after accept; in_ready constantly 1.
- Branch sweep, aluop 01, funct3 000..111 → 01000, 01000, 01010, 01010, 00010, 00010, 00011, 00011; SRAI (aluop 11, funct7 0100000, funct3 101) → 01101.
- MUL with MUL_LAT=3, funct7 0000001 funct3 000 → busy for 2 cycles, out_valid in cycle 3 with alu_ctrl 10000, is_muldiv 1, in_ready 0 during WAIT; DIV funct3 100 with DIV_LAT=33 → out_valid at exactly 33 cycles, alu_ctrl 10100.
- Backpressure: out_ready=0 for 5 cycles in VALID → alu_ctrl/out_valid stable, in_ready 0; out_ready=1 with a new in_valid → handoff with no bubble.
- flush at WAIT cycle 10 of a DIV, with in_valid=1 → next cycle IDLE, out_valid 0, busy 0, nothing loaded; the next op is accepted normally.
- rst asserted mid-WAIT and in VALID → all outputs 0 next edge, in_ready 1; with flush and rst together, reset values win.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and control encodings for the registered ALU control stage.
// Imported by the decoder and by the sequencing top.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        ALUOP_MEM = 2'b00,
        ALUOP_BR  = 2'b01,
        ALUOP_R   = 2'b10,
        ALUOP_I   = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_VALID = 2'b10
    } state_e;

    localparam logic [4:0] CTRL_ADD      = 5'b00000;
    localparam logic [4:0] CTRL_SUB_CMP  = 5'b01000;
    localparam logic [4:0] CTRL_LT       = 5'b00010;
    localparam logic [4:0] CTRL_LTU      = 5'b00011;
    localparam logic [4:0] CTRL_DEFAULT  = 5'b01010;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational decode of aluop/funct7/funct3 into the 5-bit ALU
// control code, with a flag marking RV32M multiply/divide operations.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output logic [4:0] ctrl,
    output logic       muldiv
);

    always_comb begin
        ctrl   = CTRL_DEFAULT;
        muldiv = 1'b0;
        case (aluop_e'(aluop))
            ALUOP_MEM: ctrl = CTRL_ADD;
            ALUOP_BR: begin
                case (funct3)
                    3'b000, 3'b001: ctrl = CTRL_SUB_CMP;
                    3'b100, 3'b101: ctrl = CTRL_LT;
                    3'b110, 3'b111: ctrl = CTRL_LTU;
                    default:        ctrl = CTRL_DEFAULT;
                endcase
            end
            ALUOP_R: begin
                if (funct7 == FUNCT7_MULDIV) begin
                    ctrl   = {2'b10, funct3};
                    muldiv = 1'b1;
                end else begin
                    ctrl = {1'b0, funct7[5], funct3};
                end
            end
            // Immediates carry no SUB; only SRAI looks at funct7[5].
            ALUOP_I: ctrl = {1'b0, (funct3 == 3'b101) & funct7[5], funct3};
            default: ctrl = CTRL_DEFAULT;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control stage with valid/ready handshake; MUL/DIV ops hold
// issue in WAIT until the execute unit's result is due.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W  = 5,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        aluop,
    input  logic [6:0]        funct7,
    input  logic [2:0]        funct3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              is_muldiv,
    output logic              busy
);

    if (CTRL_W < 5 || MUL_LAT < 1 || DIV_LAT < 1) begin : g_param_check
        $error("alu_ctrl_seq: CTRL_W must be >= 5 and MUL_LAT/DIV_LAT >= 1");
    end

    localparam int CNT_W = $clog2(max_int(MUL_LAT, DIV_LAT) + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);
    localparam logic MUL_ONE = (MUL_LAT == 1);
    localparam logic DIV_ONE = (DIV_LAT == 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       ctrl_q, ctrl_d;
    logic             is_muldiv_q, is_muldiv_d;

    logic [4:0]       dec_ctrl;
    logic             dec_muldiv;
    logic             accept;
    logic             lat_one;
    state_e           load_state;
    logic [CNT_W-1:0] load_cnt;

    alu_ctrl_decode u_decode (
        .aluop  (aluop),
        .funct7 (funct7),
        .funct3 (funct3),
        .ctrl   (dec_ctrl),
        .muldiv (dec_muldiv)
    );

    assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_VALID) & out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign out_valid = (state_q == ST_VALID);
    assign busy      = (state_q == ST_WAIT);
    assign is_muldiv = is_muldiv_q;

    always_comb begin
        alu_ctrl      = '0;
        alu_ctrl[4:0] = ctrl_q;
    end

    // funct3[2] splits MUL-class from DIV/REM-class latency.
    always_comb begin
        lat_one    = funct3[2] ? DIV_ONE : MUL_ONE;
        load_cnt   = funct3[2] ? DIV_CNT : MUL_CNT;
        load_state = (dec_muldiv && !lat_one) ? ST_WAIT : ST_VALID;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctrl_d      = ctrl_q;
        is_muldiv_d = is_muldiv_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d     = load_state;
                        ctrl_d      = dec_ctrl;
                        is_muldiv_d = dec_muldiv;
                        if (load_state == ST_WAIT) cnt_d = load_cnt;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) state_d = ST_VALID;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                ST_VALID: begin
                    if (accept) begin
                        state_d     = load_state;
                        ctrl_d      = dec_ctrl;
                        is_muldiv_d = dec_muldiv;
                        if (load_state == ST_WAIT) cnt_d = load_cnt;
                    end else if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ctrl_q      <= '0;
            is_muldiv_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ctrl_q      <= ctrl_d;
            is_muldiv_q <= is_muldiv_d;
        end
    end

endmodule
